shift_cmd_queue: RTL and testbench

- Sequential front end for the team's 8-bit combinational barrel shifter.
- Accepts shift commands over a valid/ready handshake and buffers them in a small FIFO.
- Applies each command in order through an internal barrel-shift datapath and presents registered results over a downstream valid/ready handshake.
- Decouples bursty producers from a stalling consumer without a combinational path from out_ready to in_ready.

---
 rtl/shift_pkg.sv | 23 ++
 rtl/barrel_shift_core.sv | 34 +++
 rtl/shift_cmd_queue.sv | 104 ++++++++++
 tb/tb_shift_cmd_queue.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared widths, command record and direction encodings for
//                the shift command queue and its barrel-shift datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    localparam int WIDTH = 8;
    localparam int AMT_W = $clog2(WIDTH);

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [AMT_W-1:0] amt;
        logic             lr;
    } shift_cmd_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/barrel_shift_core.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_shift_core
//  Description : Combinational logical barrel shifter, one mux stage per
//                shift-amount bit, zero fill in both directions.
//  Revision    : 1.0 - initial release
// ============================================================================
module barrel_shift_core
    import shift_pkg::*;
(
    input  shift_cmd_t       cmd,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] w_acc;

    // Stage k shifts by 2**k when amount bit k is set; amount 0 passes through.
    always_comb begin
        w_acc = cmd.data;
        for (int k = 0; k < AMT_W; k++) begin
            if (cmd.amt[k]) begin
                if (cmd.lr == DIR_LEFT) begin
                    w_acc = w_acc << (1 << k);
                end else begin
                    w_acc = w_acc >> (1 << k);
                end
            end
        end
    end

    assign result = w_acc;

endmodule : barrel_shift_core
`default_nettype wire

// File: rtl/shift_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : shift_cmd_queue
//  Description : Buffers shift commands in a small FIFO, applies them in order
//                through the barrel shifter and holds each result in an output
//                register with a valid/ready handshake. in_ready depends only
//                on registered occupancy, never on out_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_cmd_queue #(
    parameter int WIDTH = shift_pkg::WIDTH,
    parameter int AMT_W = shift_pkg::AMT_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [AMT_W-1:0]         in_amt,
    input  logic                     in_lr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

    shift_pkg::shift_cmd_t r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_out_valid;
    logic [WIDTH-1:0]      r_out_data;

    shift_pkg::shift_cmd_t w_in_cmd;
    shift_pkg::shift_cmd_t w_head;
    logic [WIDTH-1:0]      w_result;
    logic                  w_push;
    logic                  w_load;

    assign w_in_cmd = '{data: in_data, amt: in_amt, lr: in_lr};
    assign w_head   = r_mem[r_rd_ptr];

    // A full FIFO stays full for this cycle even if a load frees a slot.
    assign in_ready = (r_count != c_full);
    assign w_push   = in_valid && in_ready;
    assign w_load   = (r_count != '0) && (!r_out_valid || out_ready);

    barrel_shift_core u_core (
        .cmd    (w_head),
        .result (w_result)
    );

    // Command storage needs no reset: entries are only read when counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_cmd;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_load) begin
                r_count <= r_count + 1'b1;
            end else if (w_load && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Output register: load the shifted head, or empty out once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign count     = r_count;

endmodule : shift_cmd_queue
`default_nettype wire

// File: tb/tb_shift_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_cmd_queue
//  Description : Self-checking bench for shift_cmd_queue: directed scenarios
//                plus randomized traffic checked against a scoreboard of
//                arithmetically computed shift results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_cmd_queue;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       in_lr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb[$];
    logic [7:0] got[$];

    shift_cmd_queue #(.WIDTH(8), .AMT_W(3), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_lr     (in_lr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int a, input logic lr);
        int v;
        v = d;
        if (lr) v = (v * (1 << a)) % 256;
        else    v = v / (1 << a);
        return 8'(v);
    endfunction

    // One clock cycle, entered and left 1 time unit after a rising edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic [2:0] a,
                         input logic lr, input logic ordy,
                         output logic pushed, output logic popped);
        logic [7:0] exp;
        in_valid  = v;
        in_data   = d;
        in_amt    = a;
        in_lr     = lr;
        out_ready = ordy;
        #1;
        pushed = v && in_ready;
        popped = out_valid && ordy;
        if (popped) begin
            got.push_back(out_data);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got result %02h, expected no result", out_data);
            end else begin
                exp = sb.pop_front();
                if (out_data !== exp) begin
                    errors++;
                    $display("FAIL sb_order: got %02h, expected %02h", out_data, exp);
                end
            end
        end
        if (pushed) sb.push_back(ref_shift(d, int'(a), lr));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic p, q;
        int n;
        n = 0;
        while ((out_valid || count != 0) && n < 50) begin
            cycle(1'b0, 8'h00, 3'd0, 1'b0, 1'b1, p, q);
            n++;
        end
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got valid=%0b count=%0d pending=%0d, expected 0/0/0",
                     out_valid, count, sb.size());
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (count !== 3'd0)    begin errors++; $display("FAIL reset_count: got %0d, expected 0", count); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b, expected 0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %02h, expected 00", out_data); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b, expected 1", in_ready); end
    endtask

    task automatic run_four(input logic [7:0] d[4], input logic [2:0] a[4], input logic lr[4],
                            input logic [7:0] exp[4], input string name);
        logic p, q;
        got.delete();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, d[i], a[i], lr[i], 1'b1, p, q);
            if (i == 0) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL %s_latency1: got out_valid=%0b, expected 0", name, out_valid);
                end
            end
            if (i == 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp[0]) begin
                    errors++;
                    $display("FAIL %s_latency2: got valid=%0b data=%02h, expected 1/%02h",
                             name, out_valid, out_data, exp[0]);
                end
            end
        end
        drain();
        checks++;
        if (got.size() != 4) begin
            errors++; $display("FAIL %s_count: got %0d results, expected 4", name, got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++; $display("FAIL %s_result%0d: got %02h, expected %02h", name, i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_basic();
        run_four('{8'd16, 8'd16, 8'd7, 8'd7}, '{3'd2, 3'd2, 3'd3, 3'd3},
                 '{1'b1, 1'b0, 1'b1, 1'b0}, '{8'd64, 8'd4, 8'd56, 8'd0}, "basic");
    endtask

    task automatic test_edge_amounts();
        run_four('{8'hA5, 8'h80, 8'h01, 8'hFF}, '{3'd0, 3'd7, 3'd7, 3'd7},
                 '{1'b1, 1'b0, 1'b1, 1'b0}, '{8'hA5, 8'h01, 8'h80, 8'h01}, "edge");
    endtask

    task automatic test_backpressure();
        logic p, q;
        int acc;
        bit unstable;
        bit six_in;
        acc = 0;
        unstable = 0;
        got.delete();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'((acc < 5) ? acc + 1 : 6), 3'd0, 1'b1, 1'b0, p, q);
            if (p) acc++;
            if (out_valid && out_data !== 8'd1) unstable = 1;
        end
        checks++;
        if (acc != 5) begin errors++; $display("FAIL bp_accepted: got %0d, expected 5", acc); end
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full: got count=%0d in_ready=%0b, expected 4/0", count, in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd1 || unstable) begin
            errors++; $display("FAIL bp_hold: got valid=%0b data=%02h unstable=%0b, expected 1/01/0",
                               out_valid, out_data, unstable);
        end
        six_in = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(!six_in, 8'd6, 3'd0, 1'b1, 1'b1, p, q);
            if (p) six_in = 1;
        end
        checks++;
        if (got.size() != 5) begin
            errors++; $display("FAIL bp_release_count: got %0d, expected 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] !== 8'(i + 1)) begin
                    errors++; $display("FAIL bp_release%0d: got %02h, expected %02h", i, got[i], 8'(i + 1));
                end
            end
        end
        checks++;
        if (!six_in) begin errors++; $display("FAIL bp_sixth: got not accepted, expected accepted"); end
        drain();
    endtask

    task automatic test_push_pop();
        logic p, q;
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 1'b0, p, q);
        checks++;
        if (count !== 3'd2 || out_valid !== 1'b1) begin
            errors++; $display("FAIL pp_setup: got count=%0d valid=%0b, expected 2/1", count, out_valid);
        end
        cycle(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 1'b1, p, q);
        checks++;
        if (count !== 3'd2 || in_ready !== 1'b1) begin
            errors++; $display("FAIL pp_steady: got count=%0d in_ready=%0b, expected 2/1", count, in_ready);
        end
        for (int i = 0; i < 20; i++)
            cycle(1'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), p, q);
        drain();
    endtask

    task automatic test_wrap();
        logic p, q;
        int sent;
        int n;
        sent = 0;
        n = 0;
        while (sent < 3 * DEPTH + 1 && n < 400) begin
            cycle(($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom), 1'($urandom),
                  ($urandom_range(0, 2) != 0), p, q);
            if (p) sent++;
            n++;
        end
        checks++;
        if (sent != 3 * DEPTH + 1) begin
            errors++; $display("FAIL wrap_timeout: got %0d sent, expected %0d", sent, 3 * DEPTH + 1);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic p, q;
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 1'b0, p, q);
        checks++;
        if (count !== 3'd3 || out_valid !== 1'b1) begin
            errors++; $display("FAIL rst_setup: got count=%0d valid=%0b, expected 3/1", count, out_valid);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0) begin
            errors++; $display("FAIL rst_async: got valid=%0b in_ready=%0b count=%0d, expected 0/1/0",
                               out_valid, in_ready, count);
        end
        #1 rst_n = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        got.delete();
        cycle(1'b1, 8'd16, 3'd2, 1'b1, 1'b1, p, q);
        drain();
        checks++;
        if (got.size() != 1 || got[0] !== 8'd64) begin
            errors++; $display("FAIL rst_fresh: got %0d results first=%02h, expected 1 result 40",
                               got.size(), (got.size() > 0) ? got[0] : 8'h00);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_lr     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_edge_amounts();
        test_backpressure();
        test_push_pop();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shift_cmd_queue
`default_nettype wire
